// File: rtl/dm_responder_if.sv
// dm_responder_if: load/store request and response channel between
// the MEM stage (master) and the data-memory responder (slave).
// Ports: none; signals grouped below, clock/reset stay outside.
//   req_valid/req_ready  request handshake
//   req_write/addr/wdata/be  request payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata/rsp_err    response payload
interface dm_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_be,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: word RAM answering MEM-stage loads/stores with
// programmable wait states and a registered valid/ready response.
// Ports: clock (rising edge), reset (async, active low),
//        bus (dm_responder_if.slave: req_* in, rsp_* out).
// Option: define DM_ALIGN_CHECK_EN to reject misaligned requests
//         with rsp_err=1 and no RAM update.
module dm_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clock,
    input logic           reset,
    dm_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    commit;
    logic                    err_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef DM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    assign err_c = mis_q;
`else
    assign err_c = 1'b0;
`endif

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[ADDR_WIDTH-1:IDX_W+2],
                           bus.req_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        mis_d       = mis_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Ready rises one edge after reset, and stays up
                // until a request is taken.
                req_ready_d = 1'b1;
                if (req_ready_q && bus.req_valid) begin
                    wr_d        = bus.req_write;
                    idx_d       = bus.req_addr[IDX_W+1:2];
                    wdata_d     = bus.req_wdata;
                    be_d        = bus.req_be;
`ifdef DM_ALIGN_CHECK_EN
                    mis_d       = |bus.req_addr[1:0];
`endif
                    cnt_d       = WAIT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // A zero count commits on the first edge in WAIT,
                // giving a uniform WAIT_CYCLES+1 latency.
                if (cnt_q == 4'd0) begin
                    commit      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_c;
                    rsp_rdata_d = (wr_q || err_c) ? '0 : mem[idx_q];
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DM_ALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DM_ALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    // RAM is not reset; commit is gated by the reset state, so a
    // store aborted by reset never lands.
    always_ff @(posedge clock) begin
        if (commit && wr_q && !err_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and random checks of dm_responder
// against a byte-addressed memory model.
module tb_dm_responder;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int WC    = 2;
`ifdef DM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    logic [7:0] ref_mem [DEPTH*4];
    bit         ref_ok  [DEPTH*4];

    dm_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dm_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory model: bytes at (addr mod DEPTH*4), word aligned down.
    function automatic void ref_access(
        input  bit          w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [3:0]  be,
        output logic [31:0] rd,
        output logic        er,
        output bit          known
    );
        int unsigned base;
        base  = ((a / 4) % DEPTH) * 4;
        er    = ALIGN && (a % 4 != 0);
        rd    = '0;
        known = 1'b1;
        if (er) return;
        for (int i = 0; i < 4; i++) begin
            if (w) begin
                if (be[i]) begin
                    ref_mem[base+i] = d[8*i +: 8];
                    ref_ok[base+i]  = 1'b1;
                end
            end else begin
                rd[8*i +: 8] = ref_mem[base+i];
                if (!ref_ok[base+i]) known = 1'b0;
            end
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; fails++;
            $display("FAIL req_ready_timeout: req_ready=%b required 1",
                     bus.req_ready);
        end
    endtask

    task automatic drive_req(input bit w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
    endtask

    task automatic scramble_req();
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
    endtask

    // One full transaction; lat = edges from accept to rsp_valid
    // (-1 on timeout), rdy = req_ready & !rsp_valid after handshake.
    task automatic xact(
        input  bit          w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [3:0]  be,
        output logic [31:0] rd,
        output logic        er,
        output int          lat,
        output logic        rdy
    );
        wait_ready();
        drive_req(w, a, d, be);
        @(posedge clock); #1;
        scramble_req();
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        if (lat >= 50) lat = -1;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        rdy = bus.req_ready && !bus.rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata);
        end
        checks++;
        if (bus.rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL release_ready_early: got %b want 0",
                     bus.req_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, ex;
        logic er, exe, rdy;
        int lat;
        bit kn;
        ref_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ex, exe, kn);
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, rdy);
        checks++;
        if (lat !== WC + 1) begin
            fails++;
            $display("FAIL store_latency: got %0d want %0d", lat, WC + 1);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            fails++;
            $display("FAIL store_rsp: got %h/%b want 0/0", rd, er);
        end
        checks++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL store_release: got %b want 1", rdy);
        end
        ref_access(1'b0, 32'h10, 32'h0, 4'h0, ex, exe, kn);
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy);
        checks++;
        if (lat !== WC + 1) begin
            fails++;
            $display("FAIL load_latency: got %0d want %0d", lat, WC + 1);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL load_full: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, ex;
        logic er, exe, rdy;
        int lat;
        bit kn;
        ref_access(1'b1, 32'h10, 32'h000000AA, 4'h1, ex, exe, kn);
        xact(1'b1, 32'h10, 32'h000000AA, 4'h1, rd, er, lat, rdy);
        ref_access(1'b0, 32'h10, 32'h0, 4'h0, ex, exe, kn);
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy);
        checks++;
        if (rd !== 32'hDEADBEAA) begin
            fails++;
            $display("FAIL byte_enable: got %h want deadbeaa", rd);
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        wait_ready();
        drive_req(1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clock); #1;
        scramble_req();
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat !== WC + 1) begin
            fails++;
            $display("FAIL bp_latency: got %0d want %0d", lat, WC + 1);
        end
        drive_req(1'b1, 32'h10, 32'h55555555, 4'hF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEAA
                || bus.req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: got v=%b d=%h r=%b want 1/deadbeaa/0",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
        end
        scramble_req();
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0
            || bus.rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL bp_release: got r=%b v=%b d=%h want 1/0/0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        begin
            logic [31:0] rd;
            logic er, rdy;
            int l2;
            xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, l2, rdy);
            checks++;
            if (rd !== 32'hDEADBEAA) begin
                fails++;
                $display("FAIL bp_no_accept: got %h want deadbeaa", rd);
            end
        end
    endtask

    task automatic test_wrap_abort();
        logic [31:0] rd, ex;
        logic er, exe, rdy;
        int lat;
        bit kn;
        ref_access(1'b1, 32'h1010, 32'h12345678, 4'hF, ex, exe, kn);
        xact(1'b1, 32'h1010, 32'h12345678, 4'hF, rd, er, lat, rdy);
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy);
        checks++;
        if (rd !== 32'h12345678) begin
            fails++;
            $display("FAIL wrap: got %h want 12345678", rd);
        end
        wait_ready();
        drive_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
        @(posedge clock); #1;
        scramble_req();
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: got r=%b v=%b want 0/0",
                     bus.req_ready, bus.rsp_valid);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy);
        checks++;
        if (rd !== 32'h12345678) begin
            fails++;
            $display("FAIL abort_store: got %h want 12345678", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, ex;
        logic er, exe, rdy;
        int lat;
        bit kn;
        ref_access(1'b0, 32'h12, 32'h0, 4'h0, ex, exe, kn);
        xact(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat, rdy);
        checks++;
        if (rd !== ex || er !== exe || lat !== WC + 1) begin
            fails++;
            $display("FAIL mis_load: got %h/%b/%0d want %h/%b/%0d",
                     rd, er, lat, ex, exe, WC + 1);
        end
        ref_access(1'b1, 32'h13, 32'hCAFEBABE, 4'hF, ex, exe, kn);
        xact(1'b1, 32'h13, 32'hCAFEBABE, 4'hF, rd, er, lat, rdy);
        checks++;
        if (rd !== 32'h0 || er !== exe) begin
            fails++;
            $display("FAIL mis_store: got %h/%b want 0/%b", rd, er, exe);
        end
        ref_access(1'b0, 32'h10, 32'h0, 4'h0, ex, exe, kn);
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, rdy);
        checks++;
        if (rd !== ex || er !== 1'b0) begin
            fails++;
            $display("FAIL mis_after: got %h/%b want %h/0", rd, er, ex);
        end
    endtask

    task automatic test_random();
        int pool [8];
        logic [31:0] rd, ex, a, d;
        logic [3:0] be;
        logic er, exe, rdy;
        int lat;
        bit kn, w;
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(0, DEPTH - 1);
            a = ($urandom & 32'hFFFF_F000) | (32'(pool[i]) << 2);
            d = $urandom;
            ref_access(1'b1, a, d, 4'hF, ex, exe, kn);
            xact(1'b1, a, d, 4'hF, rd, er, lat, rdy);
        end
        for (int n = 0; n < 40; n++) begin
            w  = 1'($urandom);
            a  = ($urandom & 32'hFFFF_F000)
               | (32'(pool[$urandom_range(0, 7)]) << 2)
               | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            d  = $urandom;
            be = 4'($urandom);
            ref_access(w, a, d, be, ex, exe, kn);
            xact(w, a, d, be, rd, er, lat, rdy);
            checks++;
            if ((kn && rd !== ex) || er !== exe || lat !== WC + 1
                || rdy !== 1'b1) begin
                fails++;
                $display("FAIL random %0d w=%b a=%h: got %h/%b/%0d/%b want %h/%b/%0d/1",
                         n, w, a, rd, er, lat, rdy, ex, exe, WC + 1);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_backpressure();
        test_wrap_abort();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
